reservation_station: RTL

- Operand-capture reservation station for one functional unit.
- Sits upstream of the common data bus and reorder buffer. Accepts dispatched instructions tagged with their ROB destination id and snoops the CDB for missing source operands.
- Issues the oldest fully-ready entry to its functional unit through a registered valid/ready stage. The FU result later returns on the CDB to the ROB.
- Flushes with the ROB flush.

---
 rtl/reservation_station_if.sv | 42 ++++
 rtl/reservation_station.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and issue handshake bundle for the reservation station.
// The master side drives dispatch, CDB, flush and issue_ready.
interface reservation_station_if #(
  parameter int ROB_ID_W = 3,
  parameter int OP_W     = 4
);
  logic                flush;
  logic                dispatch_valid;
  logic [OP_W-1:0]     dispatch_op;
  logic [ROB_ID_W-1:0] dispatch_dest;
  logic                dispatch_src1_ready;
  logic [ROB_ID_W-1:0] dispatch_src1_tag;
  logic [15:0]         dispatch_src1_value;
  logic                dispatch_src2_ready;
  logic [ROB_ID_W-1:0] dispatch_src2_tag;
  logic [15:0]         dispatch_src2_value;
  logic                full;
  logic [ROB_ID_W-1:0] cdb_dest;
  logic [15:0]         cdb_value;
  logic                issue_valid;
  logic                issue_ready;
  logic [OP_W-1:0]     issue_op;
  logic [ROB_ID_W-1:0] issue_dest;
  logic [15:0]         issue_a;
  logic [15:0]         issue_b;

  modport master (
    output flush, dispatch_valid, dispatch_op, dispatch_dest,
           dispatch_src1_ready, dispatch_src1_tag, dispatch_src1_value,
           dispatch_src2_ready, dispatch_src2_tag, dispatch_src2_value,
           cdb_dest, cdb_value, issue_ready,
    input  full, issue_valid, issue_op, issue_dest, issue_a, issue_b
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_op, dispatch_dest,
           dispatch_src1_ready, dispatch_src1_tag, dispatch_src1_value,
           dispatch_src2_ready, dispatch_src2_tag, dispatch_src2_value,
           cdb_dest, cdb_value, issue_ready,
    output full, issue_valid, issue_op, issue_dest, issue_a, issue_b
  );
endinterface

// File: rtl/reservation_station.sv
// Operand-capture reservation station: snoops the CDB for missing operands and
// issues the oldest fully-ready instruction through a registered valid/ready stage.
module reservation_station #(
  parameter int                  DEPTH       = 4,
  parameter int                  ROB_ID_W    = 3,
  parameter logic [ROB_ID_W-1:0] INVALID_TAG = '1,
  parameter int                  OP_W        = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  reservation_station_if.slave bus
);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int RANK_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [OP_W-1:0]     op_q [DEPTH];
  logic [OP_W-1:0]     op_d [DEPTH];
  logic [ROB_ID_W-1:0] dest_q [DEPTH];
  logic [ROB_ID_W-1:0] dest_d [DEPTH];
  logic [ROB_ID_W-1:0] s1_tag_q [DEPTH];
  logic [ROB_ID_W-1:0] s1_tag_d [DEPTH];
  logic [ROB_ID_W-1:0] s2_tag_q [DEPTH];
  logic [ROB_ID_W-1:0] s2_tag_d [DEPTH];
  logic [15:0]         s1_val_q [DEPTH];
  logic [15:0]         s1_val_d [DEPTH];
  logic [15:0]         s2_val_q [DEPTH];
  logic [15:0]         s2_val_d [DEPTH];
  logic [RANK_W-1:0]   rank_q [DEPTH];
  logic [RANK_W-1:0]   rank_d [DEPTH];
  logic [OCC_W-1:0]    occ_q, occ_d, occ_after;

  logic                iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]     iss_op_q, iss_op_d;
  logic [ROB_ID_W-1:0] iss_dest_q, iss_dest_d;
  logic [15:0]         iss_a_q, iss_a_d, iss_b_q, iss_b_d;

  logic [DEPTH-1:0]    eligible;
  logic                sel_found;
  logic [RANK_W-1:0]   sel_idx, sel_rank, free_idx;
  logic                full, cdb_hit, accept, can_load, load_entry, direct, store;

  assign full       = (occ_q == OCC_W'(DEPTH));
  assign cdb_hit    = (bus.cdb_dest != INVALID_TAG);
  assign accept     = bus.dispatch_valid && !full && !bus.flush;
  assign can_load   = !iss_valid_q || bus.issue_ready;
  assign load_entry = can_load && sel_found;
  // A fully-ready dispatch goes straight to the issue register when nothing older is waiting.
  assign direct     = can_load && !sel_found && accept &&
                      bus.dispatch_src1_ready && bus.dispatch_src2_ready;
  assign store      = accept && !direct;
  assign occ_after  = occ_q - OCC_W'(load_entry);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
    assign eligible[gi] = valid_q[gi] && s1_rdy_q[gi] && s2_rdy_q[gi];
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found || rank_q[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = RANK_W'(i);
        sel_rank  = rank_q[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = RANK_W'(i);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    op_d     = op_q;
    dest_d   = dest_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    rank_d   = rank_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit && !s1_rdy_q[i] && s1_tag_q[i] == bus.cdb_dest) begin
        s1_rdy_d[i] = 1'b1;
        s1_val_d[i] = bus.cdb_value;
      end
      if (cdb_hit && !s2_rdy_q[i] && s2_tag_q[i] == bus.cdb_dest) begin
        s2_rdy_d[i] = 1'b1;
        s2_val_d[i] = bus.cdb_value;
      end
      if (load_entry && rank_q[i] > sel_rank) rank_d[i] = rank_q[i] - RANK_W'(1);
      if (load_entry && sel_idx == RANK_W'(i)) valid_d[i] = 1'b0;
      if (store && free_idx == RANK_W'(i)) begin
        valid_d[i]  = 1'b1;
        op_d[i]     = bus.dispatch_op;
        dest_d[i]   = bus.dispatch_dest;
        rank_d[i]   = occ_after[RANK_W-1:0];
        s1_tag_d[i] = bus.dispatch_src1_tag;
        s2_tag_d[i] = bus.dispatch_src2_tag;
        s1_rdy_d[i] = bus.dispatch_src1_ready;
        s2_rdy_d[i] = bus.dispatch_src2_ready;
        s1_val_d[i] = bus.dispatch_src1_value;
        s2_val_d[i] = bus.dispatch_src2_value;
        if (!bus.dispatch_src1_ready && cdb_hit && bus.dispatch_src1_tag == bus.cdb_dest) begin
          s1_rdy_d[i] = 1'b1;
          s1_val_d[i] = bus.cdb_value;
        end
        if (!bus.dispatch_src2_ready && cdb_hit && bus.dispatch_src2_tag == bus.cdb_dest) begin
          s2_rdy_d[i] = 1'b1;
          s2_val_d[i] = bus.cdb_value;
        end
      end
      if (bus.flush) valid_d[i] = 1'b0;
    end
    occ_d = bus.flush ? '0 : occ_after + OCC_W'(store);
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_dest_d  = iss_dest_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    if (load_entry) begin
      iss_valid_d = 1'b1;
      iss_op_d    = op_q[sel_idx];
      iss_dest_d  = dest_q[sel_idx];
      iss_a_d     = s1_val_q[sel_idx];
      iss_b_d     = s2_val_q[sel_idx];
    end else if (direct) begin
      iss_valid_d = 1'b1;
      iss_op_d    = bus.dispatch_op;
      iss_dest_d  = bus.dispatch_dest;
      iss_a_d     = bus.dispatch_src1_value;
      iss_b_d     = bus.dispatch_src2_value;
    end else if (bus.issue_ready) begin
      iss_valid_d = 1'b0;
    end
    if (bus.flush) iss_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      s1_rdy_q    <= '0;
      s2_rdy_q    <= '0;
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_dest_q  <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        dest_q[i]   <= '0;
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        rank_q[i]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      s1_rdy_q    <= s1_rdy_d;
      s2_rdy_q    <= s2_rdy_d;
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_dest_q  <= iss_dest_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      s1_val_q    <= s1_val_d;
      s2_val_q    <= s2_val_d;
      rank_q      <= rank_d;
    end
  end

  assign bus.full        = full;
  assign bus.issue_valid = iss_valid_q;
  assign bus.issue_op    = iss_op_q;
  assign bus.issue_dest  = iss_dest_q;
  assign bus.issue_a     = iss_a_q;
  assign bus.issue_b     = iss_b_q;
endmodule
